kv_wb_frontend: RTL and testbench

Wishbone-facing command front-end for the key/value store core. It decodes 32-bit Wishbone classic accesses from the management SoC into PUT/GET commands and buffers them in a small FIFO that feeds the core's valid/ready command port. It also captures the core's responses into a readable result register. It sits directly upstream of the key/value core inside the user-project wrapper and replaces the core's direct bit-wide Wishbone hookup.

---
 rtl/kv_pkg.sv | 34 +++
 rtl/kv_cmd_fifo.sv | 58 +++++
 rtl/kv_wb_frontend.sv | 171 +++++++++++++++++
 tb/tb_kv_wb_frontend.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_pkg.sv
// Shared definitions for the key/value Wishbone front-end: register map,
// command encoding, STATUS/RESULT bit positions and the queued command record.
package kv_pkg;

  localparam logic [7:0] REG_KEY    = 8'h00;
  localparam logic [7:0] REG_VALUE  = 8'h04;
  localparam logic [7:0] REG_CMD    = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;
  localparam logic [7:0] REG_RESULT = 8'h10;

  typedef enum logic {
    KV_GET = 1'b0,
    KV_PUT = 1'b1
  } kv_op_e;

  localparam int ST_EMPTY     = 8;
  localparam int ST_FULL      = 9;
  localparam int ST_RSP_VALID = 10;
  localparam int ST_RSP_HIT   = 11;
  localparam int ST_OVERFLOW  = 12;
  localparam int ST_RSP_LOST  = 13;
  localparam int RES_HIT      = 31;

  // Fields sized for the widest legal key/value; narrower instances zero-extend.
  localparam int KV_KEY_MAX = 32;
  localparam int KV_VAL_MAX = 31;

  typedef struct packed {
    kv_op_e                op;
    logic [KV_KEY_MAX-1:0] key;
    logic [KV_VAL_MAX-1:0] value;
  } kv_cmd_t;

endpackage

// File: rtl/kv_cmd_fifo.sv
// Show-ahead synchronous command FIFO; the head entry is visible whenever the
// FIFO is non-empty and a push into a full FIFO succeeds only alongside a pop.
module kv_cmd_fifo
  import kv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  kv_cmd_t                  din,
  input  logic                     pop,
  output kv_cmd_t                  dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  kv_cmd_t        mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Pointers carry one extra wrap bit, so their difference is the fill level.
  always_comb begin
    level     = wr_ptr_r - rd_ptr_r;
    full      = (level == (AW+1)'(DEPTH));
    empty     = (level == (AW+1)'(0));
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    if (empty) dout = '0;
    else       dout = mem_r[rd_ptr_r[AW-1:0]];
  end

endmodule

// File: rtl/kv_wb_frontend.sv
// Wishbone classic slave that turns register writes into PUT/GET commands for
// the key/value core and latches the core's responses into a RESULT register.
module kv_wb_frontend
  import kv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_W     = 16,
  parameter int          VAL_W     = 16,
  parameter int          DEPTH     = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic             cmd_op_o,
  output logic [KEY_W-1:0] cmd_key_o,
  output logic [VAL_W-1:0] cmd_value_o,
  input  logic             rsp_valid_i,
  input  logic             rsp_hit_i,
  input  logic [VAL_W-1:0] rsp_value_i,
  output logic             irq_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic             ack_r;
  logic [31:0]      dat_r;
  logic [KEY_W-1:0] key_r;
  logic [VAL_W-1:0] value_r;
  logic             overflow_r;
  logic             rsp_lost_r;
  logic             rsp_valid_r;
  logic             rsp_hit_r;
  logic [VAL_W-1:0] rsp_value_r;

  logic             req_s;
  logic             hit_s;
  logic [7:0]       off_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             push_s;
  logic             pop_s;
  logic             clr_s;
  logic             rd_result_s;
  logic             ovf_set_s;
  logic [31:0]      status_s;
  logic [31:0]      rd_data_s;
  kv_cmd_t          cmd_in_s;
  kv_cmd_t          cmd_head_s;
  logic [LW-1:0]    fifo_level_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             unused_ok_s;

  // Bus decode; a request is only seen while ack is low, which spaces acks.
  always_comb begin
    req_s       = wbs_stb_i & wbs_cyc_i & ~ack_r;
    hit_s       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    off_s       = wbs_adr_i[7:0];
    wr_en_s     = req_s & wbs_we_i & hit_s & (wbs_sel_i == 4'hF);
    rd_en_s     = req_s & ~wbs_we_i & hit_s;
    push_s      = wr_en_s & (off_s == REG_CMD);
    clr_s       = wr_en_s & (off_s == REG_STATUS);
    rd_result_s = rd_en_s & (off_s == REG_RESULT);
    pop_s       = ~fifo_empty_s & cmd_ready_i;
    ovf_set_s   = push_s & fifo_full_s & ~pop_s;
    cmd_in_s.op    = kv_op_e'(wbs_dat_i[0]);
    cmd_in_s.key   = KV_KEY_MAX'(key_r);
    cmd_in_s.value = KV_VAL_MAX'(value_r);
  end

  // STATUS word and read-data multiplexer.
  always_comb begin
    status_s               = 32'h0;
    status_s[7:0]          = 8'(fifo_level_s);
    status_s[ST_EMPTY]     = fifo_empty_s;
    status_s[ST_FULL]      = fifo_full_s;
    status_s[ST_RSP_VALID] = rsp_valid_r;
    status_s[ST_RSP_HIT]   = rsp_hit_r;
    status_s[ST_OVERFLOW]  = overflow_r;
    status_s[ST_RSP_LOST]  = rsp_lost_r;
    rd_data_s              = 32'h0;
    if (!hit_s) begin
      rd_data_s = 32'h0;
    end else begin
      case (off_s)
        REG_KEY:    rd_data_s = 32'(key_r);
        REG_VALUE:  rd_data_s = 32'(value_r);
        REG_STATUS: rd_data_s = status_s;
        REG_RESULT: begin
          rd_data_s          = 32'(rsp_value_r);
          rd_data_s[RES_HIT] = rsp_hit_r;
        end
        default:    rd_data_s = 32'h0;
      endcase
    end
  end

  // Single-cycle ack with read data valid only alongside it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0;
    end else begin
      ack_r <= req_s;
      dat_r <= rd_en_s ? rd_data_s : 32'h0;
    end
  end

  // KEY/VALUE staging registers and sticky error flags (set beats clear).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_r      <= {KEY_W{1'b0}};
      value_r    <= {VAL_W{1'b0}};
      overflow_r <= 1'b0;
      rsp_lost_r <= 1'b0;
    end else begin
      if (wr_en_s && (off_s == REG_KEY))   key_r   <= wbs_dat_i[KEY_W-1:0];
      if (wr_en_s && (off_s == REG_VALUE)) value_r <= wbs_dat_i[VAL_W-1:0];
      if (ovf_set_s)                                overflow_r <= 1'b1;
      else if (clr_s && wbs_dat_i[ST_OVERFLOW])     overflow_r <= 1'b0;
      if (rsp_valid_i && rsp_valid_r && !rd_result_s) rsp_lost_r <= 1'b1;
      else if (clr_s && wbs_dat_i[ST_RSP_LOST])       rsp_lost_r <= 1'b0;
    end
  end

  // Response capture; a new response always wins over a same-cycle RESULT read.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_value_r <= {VAL_W{1'b0}};
    end else if (rsp_valid_i) begin
      rsp_valid_r <= 1'b1;
      rsp_hit_r   <= rsp_hit_i;
      rsp_value_r <= rsp_value_i;
    end else if (rd_result_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  kv_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push_s),
    .din   (cmd_in_s),
    .pop   (pop_s),
    .dout  (cmd_head_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign cmd_valid_o = ~fifo_empty_s;
  assign cmd_op_o    = cmd_head_s.op;
  assign cmd_key_o   = cmd_head_s.key[KEY_W-1:0];
  assign cmd_value_o = cmd_head_s.value[VAL_W-1:0];
  assign irq_o       = rsp_valid_r;
  assign unused_ok_s = ^{wbs_dat_i, cmd_head_s};

endmodule

// File: tb/tb_kv_wb_frontend.sv
// Self-checking bench for kv_wb_frontend: directed scenarios plus a randomized
// run compared against a queue-based behavioural model of the register map.
module tb_kv_wb_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'h0, adr = 32'h0;
  logic        ready = 1'b0, rsp_v = 1'b0, rsp_hit = 1'b0;
  logic [15:0] rsp_val = 16'h0;
  logic        ack, valid, op, irq;
  logic [31:0] dout;
  logic [15:0] ckey, cval;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A_KEY = 32'h3000_0000, A_VAL = 32'h3000_0004, A_CMD = 32'h3000_0008;
  localparam logic [31:0] A_ST  = 32'h3000_000C, A_RES = 32'h3000_0010;

  always #5 clk = ~clk;

  kv_wb_frontend dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dout),
    .cmd_valid_o(valid), .cmd_ready_i(ready), .cmd_op_o(op), .cmd_key_o(ckey),
    .cmd_value_o(cval), .rsp_valid_i(rsp_v), .rsp_hit_i(rsp_hit), .rsp_value_i(rsp_val),
    .irq_o(irq)
  );

  // ---------------- behavioural model ----------------
  typedef struct { bit op; bit [15:0] key; bit [15:0] val; } ent_t;
  ent_t        q[$];
  bit          m_ack, m_ovf, m_lost, m_rspv, m_hit;
  bit [15:0]   m_key, m_val, m_rval;
  bit [31:0]   m_dat;

  task automatic model_reset();
    q.delete();
    m_ack = 0; m_ovf = 0; m_lost = 0; m_rspv = 0; m_hit = 0;
    m_key = 0; m_val = 0; m_rval = 0; m_dat = 0;
  endtask

  function automatic bit [31:0] model_status();
    bit [31:0] s;
    s = 32'(q.size());
    if (q.size() == 0) s = s | 32'h100;
    if (q.size() == 4) s = s | 32'h200;
    if (m_rspv) s = s | 32'h400;
    if (m_hit)  s = s | 32'h800;
    if (m_ovf)  s = s | 32'h1000;
    if (m_lost) s = s | 32'h2000;
    return s;
  endfunction

  // Advance one clock: model sees the inputs as they stood at the edge.
  task automatic cycle();
    bit req, match, pop, was_full, wr, rdres;
    bit [7:0] off;
    bit [31:0] rd;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      req   = stb && cyc && !m_ack;
      match = (adr[31:8] == 24'h300000);
      off   = adr[7:0];
      rd    = 0;
      if (match) begin
        if (off == 8'h00) rd = {16'h0, m_key};
        else if (off == 8'h04) rd = {16'h0, m_val};
        else if (off == 8'h0C) rd = model_status();
        else if (off == 8'h10) rd = {m_hit, 15'h0, m_rval};
      end
      m_dat    = (req && !we) ? rd : 0;
      wr       = req && we && match && (sel == 4'hF);
      rdres    = req && !we && match && (off == 8'h10);
      was_full = (q.size() == 4);
      pop      = ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (wr && off == 8'h08) begin
        if (!was_full || pop) q.push_back('{dat[0], m_key, m_val});
        else m_ovf = 1;
      end
      if (wr && off == 8'h00) m_key = dat[15:0];
      if (wr && off == 8'h04) m_val = dat[15:0];
      if (wr && off == 8'h0C) begin
        if (dat[12]) m_ovf = 0;
        if (dat[13]) m_lost = 0;
      end
      if (rsp_v) begin
        if (m_rspv && !rdres) m_lost = 1;
        m_rspv = 1; m_hit = rsp_hit; m_rval = rsp_val;
      end else if (rdres) begin
        m_rspv = 0;
      end
      m_ack = req;
    end
    @(negedge clk);
  endtask

  task automatic wb(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s,
                    output bit ak, output bit [31:0] rdat);
    stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = s;
    cycle();
    ak = ack; rdat = dout;
    stb = 0; cyc = 0; we = 0;
    cycle();
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d);
    bit ak; bit [31:0] r;
    wb(1, a, d, 4'hF, ak, r);
    checks++; if (ak !== 1'b1) begin failures++; $display("FAIL wr_ack adr=%h got=%b exp=1", a, ak); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ak; bit [31:0] r;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if ({ack, dout, valid, op, ckey, cval, irq} !== 68'h0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=0", {ack, dout, valid, op, ckey, cval, irq}); end
    rst_n = 1;
    wr(A_KEY, 32'h0000_0777);
    wr(A_CMD, 32'h1);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", valid); end
    stb = 1; cyc = 1; we = 1; adr = A_VAL; dat = 32'h1234; sel = 4'hF;
    #2 rst_n = 0; model_reset();
    #1;
    checks++; if ({ack, dout, valid, op, ckey, cval, irq} !== 68'h0) begin failures++;
      $display("FAIL midwrite_reset got=%h exp=0", {ack, dout, valid, op, ckey, cval, irq}); end
    cycle();
    stb = 0; cyc = 0; we = 0;
    rst_n = 1;
    cycle();
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h100) begin failures++; $display("FAIL reset_status got=%h exp=00000100", r); end
    wb(0, A_VAL, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", r); end
  endtask

  task automatic test_single_put();
    bit ak; bit [31:0] r;
    wr(A_KEY, 32'h1234); wr(A_VAL, 32'hBEEF); wr(A_CMD, 32'h1);
    checks++; if ({valid, op, ckey, cval} !== {1'b1, 1'b1, 16'h1234, 16'hBEEF}) begin failures++;
      $display("FAIL put_head got=%b %b %h %h exp=1 1 1234 beef", valid, op, ckey, cval); end
    ready = 1; cycle(); ready = 0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL put_pop got=%b exp=0", valid); end
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h100) begin failures++; $display("FAIL put_status got=%h exp=00000100", r); end
  endtask

  task automatic test_overflow();
    bit ak; bit [31:0] r;
    for (int i = 0; i < 5; i++) begin wr(A_KEY, 32'h100 + i); wr(A_CMD, 32'(i & 1)); end
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h1204) begin failures++; $display("FAIL ovf_status got=%h exp=00001204", r); end
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({valid, op, ckey} !== {1'b1, 1'(i & 1), 16'(16'h100 + i)}) begin failures++;
        $display("FAIL ovf_drain%0d got=%b %b %h exp=1 %0d %h", i, valid, op, ckey, i & 1, 16'h100 + i); end
      cycle();
    end
    ready = 0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovf_fifth_absent got=%b exp=0", valid); end
    wr(A_ST, 32'h1000);
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h100) begin failures++; $display("FAIL ovf_clear got=%h exp=00000100", r); end
  endtask

  task automatic test_full_push_pop();
    bit ak; bit [31:0] r;
    for (int i = 0; i < 4; i++) begin wr(A_KEY, 32'h200 + i); wr(A_CMD, 32'h1); end
    wr(A_KEY, 32'h204);
    stb = 1; cyc = 1; we = 1; adr = A_CMD; dat = 32'h0; sel = 4'hF; ready = 1;
    cycle();
    ready = 0; stb = 0; cyc = 0; we = 0;
    cycle();
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h204) begin failures++; $display("FAIL fpp_status got=%h exp=00000204", r); end
    ready = 1;
    for (int i = 1; i < 5; i++) begin
      checks++; if ({valid, op, ckey} !== {1'b1, (i == 4) ? 1'b0 : 1'b1, 16'(16'h200 + i)}) begin failures++;
        $display("FAIL fpp_order%0d got=%b %b %h exp key=%h", i, valid, op, ckey, 16'h200 + i); end
      cycle();
    end
    ready = 0;
  endtask

  task automatic test_response();
    bit ak; bit [31:0] r;
    rsp_v = 1; rsp_hit = 1; rsp_val = 16'h00AA; cycle(); rsp_v = 0;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rsp_irq got=%b exp=1", irq); end
    wb(0, A_RES, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h8000_00AA) begin failures++; $display("FAIL rsp_result got=%h exp=800000aa", r); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rsp_irq_clear got=%b exp=0", irq); end
    rsp_v = 1; rsp_hit = 0; rsp_val = 16'h11; cycle();
    rsp_val = 16'h22; cycle(); rsp_v = 0;
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h2500) begin failures++; $display("FAIL rsp_lost got=%h exp=00002500", r); end
    wb(0, A_RES, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h22) begin failures++; $display("FAIL rsp_overwrite got=%h exp=00000022", r); end
    wr(A_ST, 32'h2000);
    rsp_v = 1; rsp_hit = 1; rsp_val = 16'h33; cycle();
    rsp_val = 16'h44; stb = 1; cyc = 1; we = 0; adr = A_RES;
    cycle();
    rsp_v = 0; r = dout; stb = 0; cyc = 0;
    checks++; if (r !== 32'h8000_0033) begin failures++; $display("FAIL rsp_race_read got=%h exp=80000033", r); end
    cycle();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rsp_race_irq got=%b exp=1", irq); end
    wb(0, A_ST, 0, 4'hF, ak, r);
    checks++; if (r !== 32'hD00) begin failures++; $display("FAIL rsp_race_status got=%h exp=00000d00", r); end
    wb(0, A_RES, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h8000_0044) begin failures++; $display("FAIL rsp_race_result got=%h exp=80000044", r); end
  endtask

  task automatic test_bus_corners();
    bit ak; bit [31:0] r;
    wr(A_KEY, 32'h5A5A);
    wb(1, A_KEY, 32'h1111, 4'h3, ak, r);
    checks++; if (ak !== 1'b1) begin failures++; $display("FAIL sel_ack got=%b exp=1", ak); end
    wb(0, A_KEY, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h5A5A) begin failures++; $display("FAIL sel_ignored got=%h exp=00005a5a", r); end
    wb(0, 32'h3000_0040, 0, 4'hF, ak, r);
    checks++; if ({ak, r} !== {1'b1, 32'h0}) begin failures++; $display("FAIL unmapped_rd got=%b %h exp=1 0", ak, r); end
    wb(0, 32'h4000_0000, 0, 4'hF, ak, r);
    checks++; if ({ak, r} !== {1'b1, 32'h0}) begin failures++; $display("FAIL nomatch_rd got=%b %h exp=1 0", ak, r); end
    wb(0, A_CMD, 0, 4'hF, ak, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL cmd_rd got=%h exp=0", r); end
    stb = 1; cyc = 1; we = 0; adr = A_KEY;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if ({ack, dout} !== ((i % 2 == 0) ? {1'b1, 32'h5A5A} : 33'h0)) begin failures++;
        $display("FAIL b2b_ack%0d got=%b %h exp=%0d", i, ack, dout, (i % 2 == 0)); end
    end
    stb = 0; cyc = 0;
    cycle();
  endtask

  task automatic test_random();
    bit [31:0] addrs [7] = '{A_KEY, A_VAL, A_CMD, A_ST, A_RES, 32'h3000_0040, 32'h4000_0008};
    for (int i = 0; i < 400; i++) begin
      stb   = ($urandom_range(0, 3) != 0);
      cyc   = stb | 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      adr   = addrs[$urandom_range(0, 6)];
      dat   = $urandom;
      sel   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      ready = ($urandom_range(0, 3) == 0);
      rsp_v = ($urandom_range(0, 5) == 0);
      rsp_hit = 1'($urandom_range(0, 1));
      rsp_val = 16'($urandom);
      cycle();
      checks++; if ({ack, dout} !== {m_ack, m_dat}) begin failures++;
        $display("FAIL rnd_bus%0d got=%b %h exp=%b %h", i, ack, dout, m_ack, m_dat); end
      checks++; if (irq !== m_rspv) begin failures++; $display("FAIL rnd_irq%0d got=%b exp=%b", i, irq, m_rspv); end
      checks++;
      if (q.size() > 0) begin
        if ({valid, op, ckey, cval} !== {1'b1, q[0].op, q[0].key, q[0].val}) begin failures++;
          $display("FAIL rnd_head%0d got=%b %b %h %h exp=1 %b %h %h", i, valid, op, ckey, cval, q[0].op, q[0].key, q[0].val); end
      end else if ({valid, op, ckey, cval} !== 34'h0) begin failures++;
        $display("FAIL rnd_empty%0d got=%b %b %h %h exp=0", i, valid, op, ckey, cval); end
    end
    stb = 0; cyc = 0; we = 0; ready = 0; rsp_v = 0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_put();
    test_overflow();
    test_full_push_pop();
    test_response();
    test_bus_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
